// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus per-bit stability counter for slide switches.
// Emits clean levels and registered one-cycle rise/fall strobes per bit.
module sw_debounce #(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] accept;

  // A bit is accepted only after STABLE_CYCLES consecutive disagreements;
  // any agreement in between restarts the count from zero.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != SW_DB[i]) begin
        if (cnt[i] == LAST) begin
          accept[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      s1      <= '0;
      s2      <= '0;
      SW_DB   <= '0;
      SW_RISE <= '0;
      SW_FALL <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1      <= SW;
      s2      <= s1;
      SW_DB   <= (SW_DB & ~accept) | (s2 & accept);
      SW_RISE <= accept & s2;
      SW_FALL <= accept & ~s2;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4, WIDTH=10.
// Edge k is the k-th rising edge after SW changes; outputs sampled 1 ns later.
module tb_sw_debounce;

  localparam int WIDTH = 10;
  localparam int STABLE = 4;

  logic             CLOCK_50;
  logic             RESET;
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] SW_DB;
  logic [WIDTH-1:0] SW_RISE;
  logic [WIDTH-1:0] SW_FALL;

  int pass_cnt;
  int total_cnt;

  sw_debounce #(
    .WIDTH(WIDTH),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .SW(SW),
    .SW_DB(SW_DB),
    .SW_RISE(SW_RISE),
    .SW_FALL(SW_FALL)
  );

  // clock/reset block
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] exp_db, exp_rise;
    RESET = 1'b0;
    SW = 10'h3FF;
    #2;
    RESET = 1'b1;
    #1;
    total_cnt++;
    if (SW_DB !== 10'h000 || SW_RISE !== 10'h000 || SW_FALL !== 10'h000)
      $display("FAIL reset_async db=%h rise=%h fall=%h exp all 000", SW_DB, SW_RISE, SW_FALL);
    else pass_cnt++;
    step();
    step();
    RESET = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_db = (k >= 5) ? 10'h3FF : 10'h000;
      exp_rise = (k == 5) ? 10'h3FF : 10'h000;
      total_cnt++;
      if (SW_DB !== exp_db || SW_RISE !== exp_rise || SW_FALL !== 10'h000)
        $display("FAIL reset_release k=%0d db=%h rise=%h fall=%h exp db=%h rise=%h fall=000",
                 k, SW_DB, SW_RISE, SW_FALL, exp_db, exp_rise);
      else pass_cnt++;
    end
  endtask

  task automatic test_fall_all();
    logic [WIDTH-1:0] exp_db, exp_fall;
    SW = 10'h000;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_db = (k >= 5) ? 10'h000 : 10'h3FF;
      exp_fall = (k == 5) ? 10'h3FF : 10'h000;
      total_cnt++;
      if (SW_DB !== exp_db || SW_FALL !== exp_fall || SW_RISE !== 10'h000)
        $display("FAIL fall_all k=%0d db=%h rise=%h fall=%h exp db=%h rise=000 fall=%h",
                 k, SW_DB, SW_RISE, SW_FALL, exp_db, exp_fall);
      else pass_cnt++;
    end
  endtask

  task automatic test_clean_step();
    logic [WIDTH-1:0] exp_db, exp_rise;
    SW = 10'h001;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_db = (k >= 5) ? 10'h001 : 10'h000;
      exp_rise = (k == 5) ? 10'h001 : 10'h000;
      total_cnt++;
      if (SW_DB !== exp_db || SW_RISE !== exp_rise || SW_FALL !== 10'h000)
        $display("FAIL clean_step k=%0d db=%h rise=%h fall=%h exp db=%h rise=%h fall=000",
                 k, SW_DB, SW_RISE, SW_FALL, exp_db, exp_rise);
      else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    logic [WIDTH-1:0] exp_db, exp_rise;
    for (int p = 0; p < 10; p++) begin
      SW[3] = (p % 2 == 0) ? 1'b1 : 1'b0;
      for (int c = 0; c < 2; c++) begin
        step();
        total_cnt++;
        if (SW_DB !== 10'h001 || SW_RISE !== 10'h000 || SW_FALL !== 10'h000)
          $display("FAIL bounce_hold p=%0d db=%h rise=%h fall=%h exp db=001 rise=000 fall=000",
                   p, SW_DB, SW_RISE, SW_FALL);
        else pass_cnt++;
      end
    end
    SW[3] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_db = (k >= 5) ? 10'h009 : 10'h001;
      exp_rise = (k == 5) ? 10'h008 : 10'h000;
      total_cnt++;
      if (SW_DB !== exp_db || SW_RISE !== exp_rise || SW_FALL !== 10'h000)
        $display("FAIL bounce_settle k=%0d db=%h rise=%h fall=%h exp db=%h rise=%h fall=000",
                 k, SW_DB, SW_RISE, SW_FALL, exp_db, exp_rise);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    logic [WIDTH-1:0] exp_db, exp_fall;
    SW[9] = 1'b1;
    for (int k = 0; k <= 6; k++) step();
    total_cnt++;
    if (SW_DB !== 10'h209)
      $display("FAIL glitch_setup db=%h exp 209", SW_DB);
    else pass_cnt++;
    // three-cycle low pulse must be swallowed
    SW[9] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) SW[9] = 1'b1;
      step();
      total_cnt++;
      if (SW_DB !== 10'h209 || SW_FALL !== 10'h000 || SW_RISE !== 10'h000)
        $display("FAIL glitch_reject k=%0d db=%h rise=%h fall=%h exp db=209 rise=000 fall=000",
                 k, SW_DB, SW_RISE, SW_FALL);
      else pass_cnt++;
    end
    // a fresh full-length low must take the full delay, proving the count restarted
    SW[9] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_db = (k >= 5) ? 10'h009 : 10'h209;
      exp_fall = (k == 5) ? 10'h200 : 10'h000;
      total_cnt++;
      if (SW_DB !== exp_db || SW_FALL !== exp_fall || SW_RISE !== 10'h000)
        $display("FAIL glitch_recount k=%0d db=%h rise=%h fall=%h exp db=%h rise=000 fall=%h",
                 k, SW_DB, SW_RISE, SW_FALL, exp_db, exp_fall);
      else pass_cnt++;
    end
    SW[9] = 1'b1;
    for (int k = 0; k <= 6; k++) step();
    total_cnt++;
    if (SW_DB !== 10'h209)
      $display("FAIL glitch_restore db=%h exp 209", SW_DB);
    else pass_cnt++;
  endtask

  task automatic test_independence();
    logic [WIDTH-1:0] exp_db, exp_rise, exp_fall;
    SW[7:4] = 4'hA;
    for (int k = 0; k <= 8; k++) begin
      if (k == 2) SW[3:0] = 4'h5;
      step();
      exp_db = {2'b10, (k >= 5) ? 4'hA : 4'h0, (k >= 7) ? 4'h5 : 4'h9};
      exp_rise = (k == 5) ? 10'h0A0 : (k == 7) ? 10'h004 : 10'h000;
      exp_fall = (k == 7) ? 10'h008 : 10'h000;
      total_cnt++;
      if (SW_DB !== exp_db || SW_RISE !== exp_rise || SW_FALL !== exp_fall)
        $display("FAIL independence k=%0d db=%h rise=%h fall=%h exp db=%h rise=%h fall=%h",
                 k, SW_DB, SW_RISE, SW_FALL, exp_db, exp_rise, exp_fall);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_count();
    logic [WIDTH-1:0] exp_db, exp_rise;
    SW[1] = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      step();
      total_cnt++;
      if (SW_DB !== 10'h2A5)
        $display("FAIL midcount_pre k=%0d db=%h exp 2a5", k, SW_DB);
      else pass_cnt++;
    end
    #1;
    RESET = 1'b1;
    #1;
    total_cnt++;
    if (SW_DB !== 10'h000 || SW_RISE !== 10'h000 || SW_FALL !== 10'h000)
      $display("FAIL midcount_reset db=%h rise=%h fall=%h exp all 000", SW_DB, SW_RISE, SW_FALL);
    else pass_cnt++;
    step();
    RESET = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      step();
      exp_db = (k >= 5) ? 10'h2A7 : 10'h000;
      exp_rise = (k == 5) ? 10'h2A7 : 10'h000;
      total_cnt++;
      if (SW_DB !== exp_db || SW_RISE !== exp_rise || SW_FALL !== 10'h000)
        $display("FAIL midcount_post k=%0d db=%h rise=%h fall=%h exp db=%h rise=%h fall=000",
                 k, SW_DB, SW_RISE, SW_FALL, exp_db, exp_rise);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    RESET = 1'b0;
    SW = '0;
    test_reset();
    test_fall_all();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_independence();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
